// File: rtl/lcd_bus_reader.sv
// Read side of the HD44780-style 8-bit LCD bus: single register reads
// or busy-flag polling with a bounded number of attempts.
module lcd_bus_reader #(
    parameter int CLK_DIVIDE = 16,
    parameter int SETUP_CYC  = 1,
    parameter int HOLD_CYC   = 2,
    parameter int POLL_LIMIT = 1000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    output logic [7:0] oDATA,
    output logic       oDone,
    output logic       oTimeout,
    output logic       oActive,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_EN
);

    localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  EN_LAST    = 8'(CLK_DIVIDE - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [15:0] POLL_LAST  = 16'(POLL_LIMIT);

    typedef enum logic [2:0] {
        IDLE, SETUP, ENHI, ENLO, CHECK, DONE
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] poll_cnt;
    logic [15:0] poll_nxt;
    logic        poll_q;
    logic        start_q;
    logic        tmo_hit;
    logic        start_edge;
    logic        can_accept;

    assign start_edge = iStart & ~start_q;
    assign can_accept = (state == IDLE) || (state == DONE);
    assign poll_nxt   = poll_cnt + 16'd1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            poll_cnt <= 16'd0;
            poll_q   <= 1'b0;
            start_q  <= 1'b0;
            tmo_hit  <= 1'b0;
            oDATA    <= 8'd0;
            oDone    <= 1'b0;
            oTimeout <= 1'b0;
            oActive  <= 1'b0;
            LCD_RW   <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_EN   <= 1'b0;
        end else begin
            start_q <= iStart;
            if (start_edge && can_accept) begin
                oDone    <= 1'b0;
                oTimeout <= 1'b0;
                oActive  <= 1'b1;
                LCD_RW   <= 1'b1;
                LCD_RS   <= iPoll ? 1'b0 : iRS;
                LCD_EN   <= 1'b0;
                poll_q   <= iPoll;
                poll_cnt <= 16'd0;
                tmo_hit  <= 1'b0;
                cnt      <= 8'd0;
                state    <= SETUP;
            end else begin
                unique case (state)
                    IDLE: begin
                        LCD_EN <= 1'b0;
                        LCD_RW <= 1'b0;
                        LCD_RS <= 1'b0;
                    end
                    SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            cnt    <= 8'd0;
                            LCD_EN <= 1'b1;
                            state  <= ENHI;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ENHI: begin
                        // bus is sampled on the same edge that drops EN
                        if (cnt == EN_LAST) begin
                            cnt    <= 8'd0;
                            LCD_EN <= 1'b0;
                            oDATA  <= LCD_DATA_IN;
                            state  <= ENLO;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ENLO: begin
                        if (cnt == HOLD_LAST) begin
                            cnt   <= 8'd0;
                            state <= CHECK;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    CHECK: begin
                        if (poll_q && oDATA[7]) begin
                            poll_cnt <= poll_nxt;
                            if (poll_nxt == POLL_LAST) begin
                                tmo_hit <= 1'b1;
                                state   <= DONE;
                            end else begin
                                state <= SETUP;
                            end
                        end else begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        oDone    <= 1'b1;
                        oTimeout <= tmo_hit;
                        oActive  <= 1'b0;
                        LCD_RW   <= 1'b0;
                        LCD_RS   <= 1'b0;
                        LCD_EN   <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: read timing, polling, timeout,
// start filtering, async reset and back-to-back reads.
module tb_lcd_bus_reader;

    logic       iCLK;
    logic       iRST_N;
    logic       iStart;
    logic       iRS;
    logic       iPoll;
    logic [7:0] oDATA;
    logic       oDone;
    logic       oTimeout;
    logic       oActive;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_RW;
    logic       LCD_RS;
    logic       LCD_EN;

    int tests;
    int fails;
    bit poll_mode;

    lcd_bus_reader #(
        .CLK_DIVIDE(16),
        .SETUP_CYC (1),
        .HOLD_CYC  (2),
        .POLL_LIMIT(4)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iStart     (iStart),
        .iRS        (iRS),
        .iPoll      (iPoll),
        .oDATA      (oDATA),
        .oDone      (oDone),
        .oTimeout   (oTimeout),
        .oActive    (oActive),
        .LCD_DATA_IN(LCD_DATA_IN),
        .LCD_RW     (LCD_RW),
        .LCD_RS     (LCD_RS),
        .LCD_EN     (LCD_EN)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Starts one transaction and measures it until oDone (lat=-1 on expiry)
    task automatic run_txn(
        input  bit   hold,
        input  bit   exp_rs,
        output int   lat,
        output int   en_cyc,
        output int   pulses,
        output bit   bad_rs,
        output bit   bad_rw,
        output logic acc_done,
        output logic acc_act
    );
        logic prev_en;
        int   reads;
        lat    = -1;
        en_cyc = 0;
        pulses = 0;
        bad_rs = 1'b0;
        bad_rw = 1'b0;
        reads  = 0;
        @(negedge iCLK);
        iStart = 1'b1;
        @(posedge iCLK);
        #1;
        if (!hold) iStart = 1'b0;
        acc_done = oDone;
        acc_act  = oActive;
        prev_en  = LCD_EN;
        for (int k = 1; k <= 400; k++) begin
            @(posedge iCLK);
            #1;
            if (LCD_EN) begin
                en_cyc++;
                if (LCD_RS !== exp_rs) bad_rs = 1'b1;
                if (LCD_RW !== 1'b1) bad_rw = 1'b1;
            end
            if (LCD_EN && !prev_en) pulses++;
            if (!LCD_EN && prev_en) begin
                reads++;
                if (poll_mode && reads >= 3) LCD_DATA_IN = 8'h05;
            end
            prev_en = LCD_EN;
            if (oDone === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        tests++;
        if ({oDATA, oDone, oTimeout, oActive, LCD_RW, LCD_RS, LCD_EN}
            !== 14'd0) begin
            fails++;
            $display("FAIL reset_state: got %h expected 0",
                     {oDATA, oDone, oTimeout, oActive,
                      LCD_RW, LCD_RS, LCD_EN});
        end
    endtask

    task automatic test_single_read;
        int lat, en_cyc, pulses;
        bit bad_rs, bad_rw;
        logic ad, aa;
        iRS = 1'b1;
        iPoll = 1'b0;
        poll_mode = 1'b0;
        LCD_DATA_IN = 8'hA5;
        run_txn(1'b0, 1'b1, lat, en_cyc, pulses, bad_rs, bad_rw, ad, aa);
        tests++;
        if (lat !== 21) begin
            fails++;
            $display("FAIL single_latency: got %0d expected 21", lat);
        end
        tests++;
        if (en_cyc !== 16 || pulses !== 1) begin
            fails++;
            $display("FAIL single_en: got %0d cyc %0d pulses expected 16/1",
                     en_cyc, pulses);
        end
        tests++;
        if (bad_rs || bad_rw || aa !== 1'b1) begin
            fails++;
            $display("FAIL single_bus: rs_bad=%0b rw_bad=%0b act=%b",
                     bad_rs, bad_rw, aa);
        end
        tests++;
        if (oDATA !== 8'hA5) begin
            fails++;
            $display("FAIL single_data: got %h expected a5", oDATA);
        end
        tests++;
        if ({oTimeout, oActive, LCD_RW, LCD_RS, LCD_EN} !== 5'd0) begin
            fails++;
            $display("FAIL single_idle_bus: got %b expected 00000",
                     {oTimeout, oActive, LCD_RW, LCD_RS, LCD_EN});
        end
    endtask

    task automatic test_poll;
        int lat, en_cyc, pulses;
        bit bad_rs, bad_rw;
        logic ad, aa;
        iRS = 1'b1;
        iPoll = 1'b1;
        poll_mode = 1'b1;
        LCD_DATA_IN = 8'h80;
        run_txn(1'b0, 1'b0, lat, en_cyc, pulses, bad_rs, bad_rw, ad, aa);
        tests++;
        if (pulses !== 4 || lat !== 81) begin
            fails++;
            $display("FAIL poll_pulses: got %0d pulses lat %0d expected 4/81",
                     pulses, lat);
        end
        tests++;
        if (bad_rs || bad_rw) begin
            fails++;
            $display("FAIL poll_rs: rs_bad=%0b rw_bad=%0b expected 0/0",
                     bad_rs, bad_rw);
        end
        tests++;
        if (oDone !== 1'b1 || oTimeout !== 1'b0 || oDATA !== 8'h05) begin
            fails++;
            $display("FAIL poll_result: done=%b tmo=%b data=%h expected 1/0/05",
                     oDone, oTimeout, oDATA);
        end
    endtask

    task automatic test_timeout;
        int lat, en_cyc, pulses;
        bit bad_rs, bad_rw;
        logic ad, aa;
        iPoll = 1'b1;
        poll_mode = 1'b0;
        LCD_DATA_IN = 8'h80;
        run_txn(1'b0, 1'b0, lat, en_cyc, pulses, bad_rs, bad_rw, ad, aa);
        tests++;
        if (pulses !== 4 || lat !== 81) begin
            fails++;
            $display("FAIL timeout_pulses: got %0d pulses lat %0d expected 4/81",
                     pulses, lat);
        end
        tests++;
        if (oDone !== 1'b1 || oTimeout !== 1'b1 || oDATA !== 8'h80) begin
            fails++;
            $display("FAIL timeout_flags: done=%b tmo=%b data=%h expected 1/1/80",
                     oDone, oTimeout, oDATA);
        end
    endtask

    task automatic test_start_during;
        int   pulses;
        logic prev_en;
        iRS = 1'b0;
        iPoll = 1'b0;
        poll_mode = 1'b0;
        LCD_DATA_IN = 8'h3C;
        pulses = 0;
        @(negedge iCLK);
        iStart = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        tests++;
        if (oDone !== 1'b0 || oTimeout !== 1'b0) begin
            fails++;
            $display("FAIL accept_clears: done=%b tmo=%b expected 0/0",
                     oDone, oTimeout);
        end
        prev_en = LCD_EN;
        for (int k = 0; k < 60; k++) begin
            @(posedge iCLK);
            #1;
            if (k == 5) iStart = 1'b1;
            if (LCD_EN && !prev_en) pulses++;
            prev_en = LCD_EN;
        end
        tests++;
        if (pulses !== 1 || oDone !== 1'b1 || oActive !== 1'b0) begin
            fails++;
            $display("FAIL start_filter: pulses=%0d done=%b act=%b expected 1/1/0",
                     pulses, oDone, oActive);
        end
        @(negedge iCLK);
        iStart = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat, en_cyc, pulses;
        bit bad_rs, bad_rw;
        logic ad, aa;
        iRS = 1'b1;
        iPoll = 1'b0;
        LCD_DATA_IN = 8'h11;
        @(negedge iCLK);
        iStart = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        repeat (5) @(posedge iCLK);
        #2;
        tests++;
        if (LCD_EN !== 1'b1 || LCD_RS !== 1'b1) begin
            fails++;
            $display("FAIL mid_enhi: en=%b rs=%b expected 1/1", LCD_EN, LCD_RS);
        end
        iRST_N = 1'b0;
        #1;
        tests++;
        if ({LCD_EN, LCD_RW, LCD_RS, oActive, oDone, oDATA} !== 13'd0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0",
                     {LCD_EN, LCD_RW, LCD_RS, oActive, oDone, oDATA});
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        LCD_DATA_IN = 8'h3C;
        run_txn(1'b0, 1'b1, lat, en_cyc, pulses, bad_rs, bad_rw, ad, aa);
        tests++;
        if (lat !== 21 || oDATA !== 8'h3C || en_cyc !== 16) begin
            fails++;
            $display("FAIL post_reset_read: lat=%0d data=%h en=%0d expected 21/3c/16",
                     lat, oDATA, en_cyc);
        end
    endtask

    task automatic test_back_to_back;
        int lat, en_cyc, pulses;
        bit bad_rs, bad_rw;
        logic ad, aa;
        iRS = 1'b1;
        iPoll = 1'b0;
        LCD_DATA_IN = 8'h5A;
        run_txn(1'b0, 1'b1, lat, en_cyc, pulses, bad_rs, bad_rw, ad, aa);
        tests++;
        if (lat !== 21 || oDATA !== 8'h5A) begin
            fails++;
            $display("FAIL b2b_first: lat=%0d data=%h expected 21/5a", lat, oDATA);
        end
        LCD_DATA_IN = 8'hC3;
        run_txn(1'b0, 1'b1, lat, en_cyc, pulses, bad_rs, bad_rw, ad, aa);
        tests++;
        if (ad !== 1'b0 || aa !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: done=%b act=%b expected 0/1", ad, aa);
        end
        tests++;
        if (lat !== 21 || oDATA !== 8'hC3) begin
            fails++;
            $display("FAIL b2b_second: lat=%0d data=%h expected 21/c3", lat, oDATA);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        poll_mode = 1'b0;
        iRST_N = 1'b0;
        iStart = 1'b0;
        iRS = 1'b0;
        iPoll = 1'b0;
        LCD_DATA_IN = 8'h00;
        #23;
        test_reset();
        @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        test_single_read();
        test_poll();
        test_timeout();
        test_start_during();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
